// File: rtl/ns_arb_pkg.sv
// rtl/ns_arb_pkg.sv - shared index width helper and index type for the round-robin mux
package ns_arb_pkg;

    // Widest channel index any instance is expected to need; arbitration
    // arithmetic is carried at this width and sliced down per instance.
    localparam int NS_IDX_MAX_W = 16;

    typedef logic [NS_IDX_MAX_W-1:0] ns_idx_t;

    // A single channel still gets a 1-bit index so ports never collapse to zero width.
    function automatic int ns_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ns_rr_arb.sv
// rtl/ns_rr_arb.sv - combinational round-robin arbiter (lock inputs under NS_RR_MUX_PKT_LOCK_EN)
module ns_rr_arb
    import ns_arb_pkg::*;
#(
    parameter  int CH_NUM    = 4,
    localparam int IDX_WIDTH = ns_idx_w(CH_NUM)
) (
    input  logic [CH_NUM-1:0]    req,
    input  logic [IDX_WIDTH-1:0] ptr,
`ifdef NS_RR_MUX_PKT_LOCK_EN
    input  logic                 lock,
    input  logic [IDX_WIDTH-1:0] lock_idx,
`endif
    output logic [CH_NUM-1:0]    grant,
    output logic [IDX_WIDTH-1:0] idx
);

    ns_idx_t cand;
    logic    found;

    // Scan channels starting at ptr, wrapping, and grant the first requester;
    // a held packet lock pins the grant to the locked channel instead.
    always_comb begin
        grant = '0;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
`ifdef NS_RR_MUX_PKT_LOCK_EN
        if (lock) begin
            idx             = lock_idx;
            grant[lock_idx] = req[lock_idx];
        end else
`endif
        begin
            for (int k = 0; k < CH_NUM; k++) begin
                cand = ns_idx_t'(ptr) + ns_idx_t'(k);
                if (cand >= ns_idx_t'(CH_NUM)) begin
                    cand = cand - ns_idx_t'(CH_NUM);
                end
                if (!found && req[cand[IDX_WIDTH-1:0]]) begin
                    found                      = 1'b1;
                    grant[cand[IDX_WIDTH-1:0]] = 1'b1;
                    idx                        = cand[IDX_WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/ns_rr_mux.sv
// rtl/ns_rr_mux.sv - registered round-robin N:1 valid/ready mux (packet lock under NS_RR_MUX_PKT_LOCK_EN)
module ns_rr_mux
    import ns_arb_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int CH_NUM     = 4,
    localparam int IDX_WIDTH  = ns_idx_w(CH_NUM)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CH_NUM-1:0]     in_valid,
    input  logic [DATA_WIDTH-1:0] in_data [CH_NUM],
    input  logic [CH_NUM-1:0]     in_last,
    output logic [CH_NUM-1:0]     in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [IDX_WIDTH-1:0]  out_idx,
    input  logic                  out_ready
);

    logic                  load;
    logic                  xfer;
    logic [CH_NUM-1:0]     grant;
    logic [IDX_WIDTH-1:0]  gidx;
    logic [IDX_WIDTH-1:0]  ptr;
    logic [IDX_WIDTH-1:0]  ptr_next;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_last;
`ifdef NS_RR_MUX_PKT_LOCK_EN
    logic                  locked;
`endif

    ns_rr_arb #(
        .CH_NUM   (CH_NUM)
    ) u_arb (
        .req      (in_valid),
        .ptr      (ptr),
`ifdef NS_RR_MUX_PKT_LOCK_EN
        .lock     (locked),
        .lock_idx (out_idx),
`endif
        .grant    (grant),
        .idx      (gidx)
    );

    // The output register can take a beat when empty or being drained this cycle;
    // rst_n gating keeps every in_ready low while reset is held.
    assign load     = ~out_valid | out_ready;
    assign in_ready = grant & {CH_NUM{load & rst_n}};
    assign xfer     = |(in_valid & in_ready);
    assign ptr_next = (gidx == IDX_WIDTH'(CH_NUM - 1)) ? '0 : gidx + IDX_WIDTH'(1);

    // One-hot AND-OR payload select driven by the arbiter grant.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < CH_NUM; i++) begin
            sel_data |= in_data[i] & {DATA_WIDTH{grant[i]}};
            sel_last |= in_last[i] & grant[i];
        end
    end

    // Output register: load a granted beat, or empty when loadable with nothing granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_idx   <= '0;
        end else if (load) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= sel_data;
                out_last <= sel_last;
                out_idx  <= gidx;
            end
        end
    end

    // Priority pointer moves just past the served channel (only at packet end when locking).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (xfer) begin
`ifdef NS_RR_MUX_PKT_LOCK_EN
            if (sel_last) begin
                ptr <= ptr_next;
            end
`else
            ptr <= ptr_next;
`endif
        end
    end

`ifdef NS_RR_MUX_PKT_LOCK_EN
    // Lock the grant to the current channel between a non-last beat and its packet end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked <= 1'b0;
        end else if (xfer) begin
            locked <= ~sel_last;
        end
    end
`endif

endmodule

// File: tb/tb_ns_rr_mux.sv
// tb/tb_ns_rr_mux.sv - self-checking bench for ns_rr_mux with a behavioural reference model
module tb_ns_rr_mux;

    localparam int CH = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] in_valid = '0;
    logic [DW-1:0] in_data [CH];
    logic [CH-1:0] in_last = '0;
    logic [CH-1:0] in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [1:0]    out_idx;
    logic          out_ready = 1'b0;

    always #5 clk = ~clk;

    ns_rr_mux #(.DATA_WIDTH(DW), .CH_NUM(CH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_idx   (out_idx),
        .out_ready (out_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: contents of the output slot, the rotation pointer and the packet lock.
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    int            m_idx;
    int            m_ptr;
    logic          m_locked;
    logic [CH-1:0] m_acc;
    int            wait_cnt [CH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [CH-1:0] exp_grant();
        logic [CH-1:0] g;
        g = '0;
`ifdef NS_RR_MUX_PKT_LOCK_EN
        if (m_locked) begin
            g[m_idx] = in_valid[m_idx];
            return g;
        end
`endif
        for (int off = 0; off < CH; off++) begin
            int c;
            c = (m_ptr + off) % CH;
            if (in_valid[c]) begin
                g[c] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    function automatic logic [CH-1:0] exp_ready();
        if (rst_n && (!m_valid || out_ready)) return exp_grant();
        return '0;
    endfunction

    task automatic model_reset();
        m_valid  = 1'b0;
        m_data   = '0;
        m_last   = 1'b0;
        m_idx    = 0;
        m_ptr    = 0;
        m_locked = 1'b0;
        m_acc    = '0;
        for (int c = 0; c < CH; c++) wait_cnt[c] = 0;
    endtask

    task automatic model_clk();
        logic [CH-1:0] r;
        if (!rst_n) begin
            model_reset();
            return;
        end
        r     = exp_ready();
        m_acc = r;
        if (!m_valid || out_ready) begin
            if (r != '0) begin
                for (int c = 0; c < CH; c++) begin
                    if (r[c]) begin
                        m_valid = 1'b1;
                        m_data  = in_data[c];
                        m_last  = in_last[c];
                        m_idx   = c;
`ifdef NS_RR_MUX_PKT_LOCK_EN
                        if (in_last[c]) begin
                            m_locked = 1'b0;
                            m_ptr    = (c + 1) % CH;
                        end else begin
                            m_locked = 1'b1;
                        end
`else
                        m_ptr = (c + 1) % CH;
`endif
                    end
                end
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic compare();
        chk("out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("out_data", out_data, m_data);
            chk("out_last", out_last, m_last);
            chk("out_idx", out_idx, m_idx);
        end
        chk("in_ready", in_ready, exp_ready());
`ifndef NS_RR_MUX_PKT_LOCK_EN
        for (int c = 0; c < CH; c++) begin
            if (in_valid[c] && rst_n) begin
                if (in_ready[c]) begin
                    chk("fair_wait", wait_cnt[c] <= CH - 1, 1);
                    wait_cnt[c] = 0;
                end else if (in_ready != '0) begin
                    wait_cnt[c]++;
                end
            end else begin
                wait_cnt[c] = 0;
            end
        end
`endif
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic tick();
        #1;
        compare();
        @(posedge clk);
        model_clk();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = '0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    logic [DW-1:0] rr_data [5];
    int            seq_idx [5];
    int            beat;

    initial begin
        for (int c = 0; c < CH; c++) in_data[c] = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Idle after reset: nothing offered, nothing granted.
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("idle_out_valid", out_valid, 0);
            chk("idle_out_idx", out_idx, 0);
            chk("idle_in_ready", in_ready, 4'b0000);
        end

        // All channels continuously valid with the output always drained.
        rr_data[0] = 8'h10; rr_data[1] = 8'h21; rr_data[2] = 8'h32; rr_data[3] = 8'h43; rr_data[4] = 8'h10;
        in_data[0] = 8'h10; in_data[1] = 8'h21; in_data[2] = 8'h32; in_data[3] = 8'h43;
        in_last   = 4'hF;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_valid", out_valid, 1);
            chk("rr_data", out_data, rr_data[k]);
            chk("rr_idx", out_idx, k % CH);
        end

        // Single channel into a stalled output.
        do_reset();
        in_valid   = 4'b0100;
        in_data[2] = 8'hA5;
        out_ready  = 1'b0;
        #1;
        chk("stall_first_ready", in_ready, 4'b0100);
        tick();
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, 8'hA5);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_in_ready", in_ready, 4'b0000);
            tick();
            chk("stall_hold_valid", out_valid, 1);
            chk("stall_hold_data", out_data, 8'hA5);
        end
        out_ready = 1'b1;
        tick();
        in_valid = '0;
        tick();
        chk("stall_drained", out_valid, 0);

        // Pointer sits at 3: ch3 must win over ch0, then wrap to ch0.
        in_valid   = 4'b1001;
        in_data[0] = 8'h01;
        in_data[3] = 8'h03;
        tick();
        chk("wrap_first_idx", out_idx, 3);
        chk("wrap_first_data", out_data, 8'h03);
        tick();
        chk("wrap_second_idx", out_idx, 0);
        in_valid = '0;
        tick();

        // Reset asserted while a beat is stalled in the output.
        in_valid  = 4'b0010;
        out_ready = 1'b0;
        tick();
        in_valid = '0;
        tick();
        chk("pre_reset_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", out_valid, 0);
        chk("async_reset_ready", in_ready, 4'b0000);
        model_reset();
        tick();
        rst_n     = 1'b1;
        in_valid  = 4'b0110;
        out_ready = 1'b1;
        tick();
        chk("post_reset_idx", out_idx, 1);
        in_valid = '0;
        tick();

`ifdef NS_RR_MUX_PKT_LOCK_EN
        // ch1 sends a three-beat packet while ch0 and ch2 are also offering single beats.
        do_reset();
        seq_idx[0] = 0; seq_idx[1] = 1; seq_idx[2] = 1; seq_idx[3] = 1; seq_idx[4] = 2;
        beat       = 0;
        in_data[0] = 8'h50;
        in_data[2] = 8'h52;
        in_valid   = 4'b0111;
        out_ready  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_data[1] = 8'h60 + 8'(beat);
            in_last    = {2'b01, (beat == 2), 1'b1};
            tick();
            chk("lock_seq_idx", out_idx, seq_idx[k]);
            if (m_acc[1]) beat++;
            if (beat == 3) in_valid[1] = 1'b0;
        end
        in_valid = '0;
        tick();
`endif

        // Randomised traffic: producers hold each beat until the model says it was taken.
        do_reset();
        in_valid = '0;
        m_acc    = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < CH; c++) begin
                if (!in_valid[c] || m_acc[c]) begin
                    in_valid[c] = ($urandom_range(0, 2) != 0);
                    in_data[c]  = 8'($urandom);
                    in_last[c]  = ($urandom_range(0, 2) == 0);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
